// File: rtl/mmio_responder.sv
// MMIO device window: tohost halt register, console TX FIFO and an optional machine timer.
// Define MMIO_RESPONDER_TIMER_EN to build the mtime/mtimecmp timer block.
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_read_enable,
    input  logic [31:0] in_read_address,
    output logic [31:0] out_read_data,
    output logic        out_read_exception_valid,
    output logic [3:0]  out_read_exception_code,
    input  logic        in_write_enable,
    input  logic [31:0] in_write_address,
    input  logic [31:0] in_write_data,
    output logic        out_write_exception_valid,
    output logic [3:0]  out_write_exception_code,
    output logic        out_console_valid,
    output logic [7:0]  out_console_char,
    input  logic        in_console_ready,
    output logic        out_timer_interrupt,
    output logic        out_halt,
    output logic [31:0] out_halt_code
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [11:0] OFS_TOHOST   = 12'h000;
    localparam logic [11:0] OFS_CONSOLE  = 12'h004;
    localparam logic [11:0] OFS_MTIME_LO = 12'h008;
    localparam logic [11:0] OFS_MTIME_HI = 12'h00C;
    localparam logic [11:0] OFS_CMP_LO   = 12'h010;
    localparam logic [11:0] OFS_CMP_HI   = 12'h014;

    // Timer offsets stay mapped even without the timer so software never faults on them.
    function automatic logic is_mapped(input logic [11:0] ofs);
        return (ofs == OFS_TOHOST) || (ofs == OFS_CONSOLE) ||
               (ofs == OFS_MTIME_LO) || (ofs == OFS_MTIME_HI) ||
               (ofs == OFS_CMP_LO) || (ofs == OFS_CMP_HI);
    endfunction

    logic [11:0] rd_ofs;
    logic [11:0] wr_ofs;
    logic        rd_hit;
    logic        wr_hit;
    logic        wr_ok;

    assign rd_ofs = in_read_address[11:0];
    assign wr_ofs = in_write_address[11:0];
    assign rd_hit = in_read_enable && !RESET && (in_read_address[31:12] == BASE_ADDR[31:12]);
    assign wr_hit = in_write_enable && !RESET && (in_write_address[31:12] == BASE_ADDR[31:12]);

    always_comb begin
        out_write_exception_valid = 1'b0;
        out_write_exception_code  = 4'd0;
        wr_ok                     = 1'b0;
        if (wr_hit) begin
            if (in_write_address[1:0] != 2'b00) begin
                out_write_exception_valid = 1'b1;
                out_write_exception_code  = 4'd6;
            end else if (!is_mapped(wr_ofs)) begin
                out_write_exception_valid = 1'b1;
                out_write_exception_code  = 4'd7;
            end else begin
                wr_ok = 1'b1;
            end
        end
    end

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             full;
    logic             push;
    logic             pop;
    logic             push_ok;
    logic [7:0]       count_byte;

    assign full              = (count == CNT_W'(FIFO_DEPTH));
    assign push              = wr_ok && (wr_ofs == OFS_CONSOLE);
    assign pop               = out_console_valid && in_console_ready;
    // A pop in the same cycle frees the slot, so a push to a full FIFO is still taken.
    assign push_ok           = push && (!full || pop);
    assign out_console_valid = (count != '0);
    assign out_console_char  = fifo_mem[rd_ptr];
    assign count_byte        = 8'(count);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count <= count - CNT_W'(1);
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= in_write_data[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_halt      <= 1'b0;
            out_halt_code <= '0;
        end else if (wr_ok && (wr_ofs == OFS_TOHOST) && in_write_data[0] && !out_halt) begin
            out_halt      <= 1'b1;
            out_halt_code <= {1'b0, in_write_data[31:1]};
        end
    end

`ifdef MMIO_RESPONDER_TIMER_EN
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        timer_irq;

    // A software write to either mtime half replaces the whole increment for that cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            timer_irq <= 1'b0;
        end else begin
            if (wr_ok && (wr_ofs == OFS_MTIME_LO)) begin
                mtime <= {mtime[63:32], in_write_data};
            end else if (wr_ok && (wr_ofs == OFS_MTIME_HI)) begin
                mtime <= {in_write_data, mtime[31:0]};
            end else begin
                mtime <= mtime + 64'd1;
            end
            if (wr_ok && (wr_ofs == OFS_CMP_LO)) begin
                mtimecmp <= {mtimecmp[63:32], in_write_data};
            end
            if (wr_ok && (wr_ofs == OFS_CMP_HI)) begin
                mtimecmp <= {in_write_data, mtimecmp[31:0]};
            end
            timer_irq <= (mtime >= mtimecmp);
        end
    end

    assign out_timer_interrupt = timer_irq;
`else
    assign out_timer_interrupt = 1'b0;
`endif

    always_comb begin
        out_read_data            = '0;
        out_read_exception_valid = 1'b0;
        out_read_exception_code  = 4'd0;
        if (rd_hit) begin
            if (in_read_address[1:0] != 2'b00) begin
                out_read_exception_valid = 1'b1;
                out_read_exception_code  = 4'd4;
            end else if (!is_mapped(rd_ofs)) begin
                out_read_exception_valid = 1'b1;
                out_read_exception_code  = 4'd5;
            end else begin
                case (rd_ofs)
                    OFS_CONSOLE:  out_read_data = {23'b0, overflow, count_byte};
`ifdef MMIO_RESPONDER_TIMER_EN
                    OFS_MTIME_LO: out_read_data = mtime[31:0];
                    OFS_MTIME_HI: out_read_data = mtime[63:32];
                    OFS_CMP_LO:   out_read_data = mtimecmp[31:0];
                    OFS_CMP_HI:   out_read_data = mtimecmp[63:32];
`endif
                    default:      out_read_data = '0;
                endcase
            end
        end
    end

endmodule
